// File: rtl/sample_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_packer_pkg
// Description : Shared types and the majority rule for the sample packer and
//               the downstream 4-sample majority-vote stage. The majority rule
//               lives here so the packer and the majority stage's checker
//               evaluate exactly the same expression.
// Revision    : 1.0 - initial release
// ============================================================================
package sample_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pk_state_t;

  // Widest window the majority helper understands.
  localparam int c_MAX_WIDTH = 16;

  // Majority of the low w bits of v: 1 iff ones > zeros, a tie gives 0.
  function automatic logic maj_of(input logic [15:0] v, input int w);
    int ones;
    ones = 0;
    for (int i = 0; i < c_MAX_WIDTH; i++) begin
      if (i < w) ones += int'(v[i]);
    end
    return (2 * ones) > w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_packer_popcount_maj.sv
`default_nettype none
// ============================================================================
// Module      : popcount_maj
// Description : Combinational population count of a WIDTH-bit window and the
//               resulting majority bit (2*ones > WIDTH, ties give 0).
// Ports       : v_i   [WIDTH-1:0] window to evaluate
//               maj_o             majority bit
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_maj #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] v_i,
  output logic             maj_o
);

  // Enough bits to hold a count of WIDTH.
  localparam int c_OW = $clog2(WIDTH + 1);

  logic [c_OW-1:0] w_ones;

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + c_OW'(v_i[i]);
    end
  end

  // {ones,0} is 2*ones; WIDTH always fits in c_OW+1 bits.
  assign maj_o = ({w_ones, 1'b0} > (c_OW + 1)'(WIDTH));

endmodule
`default_nettype wire

// File: rtl/sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : sample_packer
// Description : Serial-to-window packer. Collects WIDTH sample bits LSB-first
//               and presents the window with a valid/ready handshake, together
//               with a registered majority bit and a completed-window counter.
// Ports       : clk, rst            clock, asynchronous active-high reset
//               sin, sin_valid      sample bit and its valid
//               sin_ready           packer can take a sample this cycle
//               flush               close a partial window early (0-padded)
//               win, win_valid      window (bit 0 oldest) and its valid
//               win_ready           downstream consumes the window
//               maj                 majority of win (tie gives 0)
//               frame_cnt           completed output handshakes, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] win,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             maj,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int c_IDX_W = $clog2(WIDTH);

  pk_state_t          state_q, state_d;
  logic [c_IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   win_q, win_d;
  logic               win_valid_q, win_valid_d;
  logic               maj_q, maj_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   w_assembled;
  logic               w_maj;
  logic               w_close;

  // Bits at and above idx_q are always 0 while filling (the register is
  // cleared whenever a window closes), so OR-ing the new sample in at idx_q
  // is enough. In HOLD idx_q is 0, which gives the "sample lands in bit 0"
  // value needed when a transfer coincides with an accepted sample.
  assign w_assembled = shreg_q | ({{(WIDTH-1){1'b0}}, sin & sin_valid} << idx_q);

  popcount_maj #(
    .WIDTH (WIDTH)
  ) u_popcount_maj (
    .v_i   (w_assembled),
    .maj_o (w_maj)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    maj_d       = maj_q;
    cnt_d       = cnt_q;
    sin_ready   = 1'b1;
    w_close     = 1'b0;

    case (state_q)
      FILL: begin
        sin_ready = 1'b1;
        // Flush only closes a window that would contain at least one sample.
        w_close = (sin_valid && (idx_q == c_IDX_W'(WIDTH - 1)))
                || (flush && ((idx_q != '0) || sin_valid));
        if (w_close) begin
          win_d       = w_assembled;
          maj_d       = w_maj;
          win_valid_d = 1'b1;
          idx_d       = '0;
          shreg_d     = '0;
          state_d     = HOLD;
        end else if (sin_valid) begin
          shreg_d = w_assembled;
          idx_d   = idx_q + c_IDX_W'(1);
        end
      end
      HOLD: begin
        sin_ready = win_ready;
        if (win_ready) begin
          win_d       = '0;
          maj_d       = 1'b0;
          win_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = FILL;
          if (sin_valid) begin
            shreg_d = w_assembled;
            idx_d   = c_IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      shreg_q     <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      maj_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      maj_q       <= maj_d;
      cnt_q       <= cnt_d;
    end
  end

  assign win       = win_q;
  assign win_valid = win_valid_q;
  assign maj       = maj_q;
  assign frame_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_packer
// Description : Self-checking bench for sample_packer. Two instances (WIDTH=4
//               and WIDTH=5) share the same input stream; each is tracked by
//               a behavioural model of accepted samples, held windows and
//               completed handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_packer;
  import sample_packer_pkg::*;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       sin_valid;
  logic       flush;
  logic       win_ready;

  logic       sin_ready4, win_valid4, maj4;
  logic [3:0] win4;
  logic [7:0] cnt4;
  logic       sin_ready5, win_valid5, maj5;
  logic [4:0] win5;
  logic [7:0] cnt5;

  int vectors    = 0;
  int miscompares = 0;

  // Model state, index 0 = WIDTH 4, index 1 = WIDTH 5.
  int          W    [2];
  logic [15:0] pv   [2];   // samples collected for the open window
  int          pn   [2];   // number of samples collected
  bit          hold [2];   // a window is being presented
  logic [15:0] hw   [2];   // the presented window
  int          cnt  [2];   // completed handshakes

  sample_packer #(.WIDTH(4), .CNT_W(8)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sin_ready (sin_ready4),
    .flush     (flush),
    .win       (win4),
    .win_valid (win_valid4),
    .win_ready (win_ready),
    .maj       (maj4),
    .frame_cnt (cnt4)
  );

  sample_packer #(.WIDTH(5), .CNT_W(8)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sin_ready (sin_ready5),
    .flush     (flush),
    .win       (win5),
    .win_valid (win_valid5),
    .win_ready (win_ready),
    .maj       (maj5),
    .frame_cnt (cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] o_win(input int k);
    return (k == 0) ? 16'(win4) : 16'(win5);
  endfunction
  function automatic logic o_valid(input int k);
    return (k == 0) ? win_valid4 : win_valid5;
  endfunction
  function automatic logic o_maj(input int k);
    return (k == 0) ? maj4 : maj5;
  endfunction
  function automatic logic o_rdy(input int k);
    return (k == 0) ? sin_ready4 : sin_ready5;
  endfunction
  function automatic logic [7:0] o_cnt(input int k);
    return (k == 0) ? cnt4 : cnt5;
  endfunction

  // Majority by counting: more ones than zeros.
  function automatic bit ref_maj(input logic [15:0] v, input int w);
    int n;
    n = 0;
    for (int i = 0; i < w; i++) n += int'(v[i]);
    return n > (w - n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      pv[k] = '0; pn[k] = 0; hold[k] = 1'b0; hw[k] = '0; cnt[k] = 0;
    end
  endtask

  // One clock cycle of stimulus with full model update and output checks.
  task automatic step(input bit v, input bit b, input bit fl, input bit wr);
    bit acc, was;
    @(negedge clk);
    sin = b; sin_valid = v; flush = fl; win_ready = wr;
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("sin_ready_w%0d", W[k]), 32'(o_rdy(k)), 32'(!hold[k] || wr));
    for (int k = 0; k < 2; k++) begin
      acc = v && (!hold[k] || wr);
      was = hold[k];
      if (hold[k] && wr) begin
        hold[k] = 1'b0;
        cnt[k]++;
      end
      if (acc) begin
        pv[k][pn[k]] = b;
        pn[k]++;
      end
      if (!was && ((pn[k] == W[k]) || (fl && pn[k] > 0))) begin
        hw[k]   = pv[k];
        hold[k] = 1'b1;
        pv[k]   = '0;
        pn[k]   = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("win_valid_w%0d", W[k]), 32'(o_valid(k)), 32'(hold[k]));
      chk($sformatf("win_w%0d", W[k]), 32'(o_win(k)), hold[k] ? 32'(hw[k]) : 32'd0);
      chk($sformatf("maj_w%0d", W[k]), 32'(o_maj(k)),
          hold[k] ? 32'(ref_maj(hw[k], W[k])) : 32'd0);
      chk($sformatf("frame_cnt_w%0d", W[k]), 32'(o_cnt(k)), 32'(cnt[k] % 256));
      if (hold[k])
        chk($sformatf("maj_of_w%0d", W[k]), 32'(o_maj(k)), 32'(maj_of(o_win(k), W[k])));
    end
  endtask

  // Reset asserted between clock edges; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    sin_valid = 1'b0; flush = 1'b0; rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid_w%0d", W[k]), 32'(o_valid(k)), 32'd0);
      chk($sformatf("rst_win_w%0d", W[k]), 32'(o_win(k)), 32'd0);
      chk($sformatf("rst_maj_w%0d", W[k]), 32'(o_maj(k)), 32'd0);
      chk($sformatf("rst_cnt_w%0d", W[k]), 32'(o_cnt(k)), 32'd0);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send4(input logic [3:0] bits);
    for (int i = 0; i < 4; i++) step(1'b1, bits[i], 1'b0, 1'b1);
  endtask

  initial begin
    int pulses;
    W[0] = 4; W[1] = 5;
    model_clear();
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; flush = 1'b0; win_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_win", 32'(win4), 32'd0);
    chk("reset_valid", 32'(win_valid4), 32'd0);
    chk("reset_maj", 32'(maj4), 32'd0);
    chk("reset_cnt", 32'(cnt4), 32'd0);
    chk("reset_sin_ready", 32'(sin_ready4), 32'd1);
    chk("reset_sin_ready_w5", 32'(sin_ready5), 32'd1);

    // Samples 1,1,0,1 -> 4'b1011, majority 1, valid for one cycle.
    send4(4'b1011);
    chk("tp1_win", 32'(win4), 32'hB);
    chk("tp1_maj", 32'(maj4), 32'd1);
    chk("tp1_valid", 32'(win_valid4), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("tp1_valid_drop", 32'(win_valid4), 32'd0);
    chk("tp1_cnt", 32'(cnt4), 32'd1);

    // Tie, all zeros, all ones.
    send4(4'b1001);
    chk("tp2_tie_win", 32'(win4), 32'h9);
    chk("tp2_tie_maj", 32'(maj4), 32'd0);
    send4(4'b0000);
    chk("tp2_zero_maj", 32'(maj4), 32'd0);
    send4(4'b1111);
    chk("tp2_ones_maj", 32'(maj4), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: window 0111 held while sin_valid stays up.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("tp3_hold_win", 32'(win4), 32'h7);
      chk("tp3_hold_maj", 32'(maj4), 32'd1);
      chk("tp3_hold_ready", 32'(sin_ready4), 32'd0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);   // transfer + sample into bit 0
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("tp3_restart_win", 32'(win4), 32'h9);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Flush cases.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("tp4_flush_win", 32'(win4), 32'h3);
    chk("tp4_flush_maj", 32'(maj4), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("tp4_flush_incl_win", 32'(win4), 32'h7);
    chk("tp4_flush_incl_maj", 32'(maj4), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("tp4_flush_empty", 32'(win_valid4), 32'd0);

    // Reset mid-window discards partial samples.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    do_reset();
    send4(4'b1111);
    chk("tp5_win", 32'(win4), 32'hF);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("tp5_cnt", 32'(cnt4), 32'd1);

    // 256 back-to-back windows: counter wraps, no input stall.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 1024; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      if (win_valid4) pulses++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("tp6_pulses", 32'(pulses), 32'd256);
    chk("tp6_wrap", 32'(cnt4), 32'd0);

    // WIDTH=5: samples 1,1,1,0,0 -> majority 1.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("tp7_w5_win", 32'(win5), 32'h07);
    chk("tp7_w5_maj", 32'(maj5), 32'd1);

    // Random traffic with backpressure and flushes.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
